// File: rtl/ahb_rom_arbiter.sv
// Two-port AHB-Lite read front end sharing one single-port boot ROM (1-cycle latency), round-robin arbitrated.
// Build option ROM_ARB_WERR_EN: writes get a two-cycle ERROR response instead of a zero-wait OKAY discard.
module ahb_rom_arbiter #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ROM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hsel0_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr0_i,
  input  logic                      hwrite0_i,
  input  logic [1:0]                htrans0_i,
  input  logic [2:0]                hsize0_i,
  input  logic                      hready0_i,
  output logic [AHB_DATA_WIDTH-1:0] hrdata0_o,
  output logic                      hreadyout0_o,
  output logic                      hresp0_o,
  input  logic                      hsel1_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr1_i,
  input  logic                      hwrite1_i,
  input  logic [1:0]                htrans1_i,
  input  logic [2:0]                hsize1_i,
  input  logic                      hready1_i,
  output logic [AHB_DATA_WIDTH-1:0] hrdata1_o,
  output logic                      hreadyout1_o,
  output logic                      hresp1_o,
  output logic                      rom_req_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [AHB_DATA_WIDTH-1:0] rom_rdata_i,
  output logic [2:0]                dbg_state0_o,
  output logic [2:0]                dbg_state1_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
`ifdef ROM_ARB_WERR_EN
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;
`endif

  // Handshake: an address phase is taken only when hsel & hready & htrans[1]; hready is the
  // bus-level "previous data phase done", hreadyout low stretches this port's data phase.
  logic [1:0]                     hsel, hready, hwrite, trans_act;
  logic [1:0][ROM_ADDR_WIDTH-1:0] addr;
  logic [1:0][2:0]                state_q, state_d;
  logic [1:0][ROM_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                           last_gnt_q;
  logic [1:0] in_data, in_wait, in_err1, in_err2;
  logic [1:0] accept, new_rd, cand, gnt;
  logic       prio0;
  logic       unused;

  assign hsel      = {hsel1_i, hsel0_i};
  assign hready    = {hready1_i, hready0_i};
  assign hwrite    = {hwrite1_i, hwrite0_i};
  assign trans_act = {htrans1_i[1], htrans0_i[1]};
  assign addr      = {haddr1_i[ROM_ADDR_WIDTH-1:0], haddr0_i[ROM_ADDR_WIDTH-1:0]};
  assign unused    = ^{hsize0_i, hsize1_i, htrans0_i[0], htrans1_i[0],
                       haddr0_i[AHB_ADDR_WIDTH-1:ROM_ADDR_WIDTH],
                       haddr1_i[AHB_ADDR_WIDTH-1:ROM_ADDR_WIDTH]};

  assign in_data = {state_q[1] == ST_DATA, state_q[0] == ST_DATA};
  assign in_wait = {state_q[1] == ST_WAIT, state_q[0] == ST_WAIT};
`ifdef ROM_ARB_WERR_EN
  assign in_err1 = {state_q[1] == ST_ERR1, state_q[0] == ST_ERR1};
  assign in_err2 = {state_q[1] == ST_ERR2, state_q[0] == ST_ERR2};
`else
  assign in_err1 = 2'b00;
  assign in_err2 = 2'b00;
`endif

  // A stalled port cannot see a new address phase; gating here keeps that true even on a misbehaving bus.
  assign accept = hsel & hready & trans_act & ~in_wait & ~in_err1;
  assign new_rd = accept & ~hwrite;
  assign cand   = new_rd | in_wait;

  // A waiting port always wins; a tie of two fresh requests goes to the port not granted last.
  always_comb begin
    if (in_wait[0] != in_wait[1]) prio0 = in_wait[0];
    else                          prio0 = last_gnt_q;
  end

  assign gnt[0] = cand[0] & (~cand[1] | prio0);
  assign gnt[1] = cand[1] & ~gnt[0];

  assign rom_req_o = (|gnt) & ~rst;

  always_comb begin
    rom_addr_o = '0;
    if (!rst) begin
      if (gnt[0])      rom_addr_o = in_wait[0] ? pend_addr_q[0] : addr[0];
      else if (gnt[1]) rom_addr_o = in_wait[1] ? pend_addr_q[1] : addr[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    for (int p = 0; p < 2; p++) begin
      case (state_q[p])
        ST_WAIT: state_d[p] = ST_DATA;
`ifdef ROM_ARB_WERR_EN
        ST_ERR1: state_d[p] = ST_ERR2;
`endif
        default: begin
          if (new_rd[p]) begin
            state_d[p] = gnt[p] ? ST_DATA : ST_WAIT;
            if (!gnt[p]) pend_addr_d[p] = addr[p];
          end
`ifdef ROM_ARB_WERR_EN
          else if (accept[p] && hwrite[p]) state_d[p] = ST_ERR1;
`endif
          else state_d[p] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= {ST_IDLE, ST_IDLE};
      pend_addr_q <= '0;
      last_gnt_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      if (gnt[0])      last_gnt_q <= 1'b0;
      else if (gnt[1]) last_gnt_q <= 1'b1;
    end
  end

  assign hrdata0_o    = in_data[0] ? rom_rdata_i : '0;
  assign hrdata1_o    = in_data[1] ? rom_rdata_i : '0;
  assign hreadyout0_o = ~(in_wait[0] | in_err1[0]);
  assign hreadyout1_o = ~(in_wait[1] | in_err1[1]);
  assign hresp0_o     = in_err1[0] | in_err2[0];
  assign hresp1_o     = in_err1[1] | in_err2[1];
  assign dbg_state0_o = state_q[0];
  assign dbg_state1_o = state_q[1];

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Bench for ahb_rom_arbiter: directed sequences, a vector table and a randomized run against a transfer-level model.
`timescale 1ns/1ps
module tb_ahb_rom_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 16;
`ifdef ROM_ARB_WERR_EN
  localparam bit WERR = 1'b1;
`else
  localparam bit WERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    hsel, hwrite, hready;
  logic [AW-1:0] haddr [2];
  logic [1:0]    htrans [2];
  logic [2:0]    hsize [2];
  wire  [DW-1:0] hrdata [2];
  wire  [1:0]    hreadyout, hresp;
  wire  [2:0]    dbg_state [2];
  wire           rom_req;
  wire  [RW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;

  ahb_rom_arbiter #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .ROM_ADDR_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .hsel0_i(hsel[0]), .haddr0_i(haddr[0]), .hwrite0_i(hwrite[0]), .htrans0_i(htrans[0]),
    .hsize0_i(hsize[0]), .hready0_i(hready[0]), .hrdata0_o(hrdata[0]),
    .hreadyout0_o(hreadyout[0]), .hresp0_o(hresp[0]),
    .hsel1_i(hsel[1]), .haddr1_i(haddr[1]), .hwrite1_i(hwrite[1]), .htrans1_i(htrans[1]),
    .hsize1_i(hsize[1]), .hready1_i(hready[1]), .hrdata1_o(hrdata[1]),
    .hreadyout1_o(hreadyout[1]), .hresp1_o(hresp[1]),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
    .dbg_state0_o(dbg_state[0]), .dbg_state1_o(dbg_state[1])
  );

  function automatic logic [DW-1:0] rom_fn(input logic [RW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
  endfunction

  // ROM macro: data valid the cycle after the strobe, garbage otherwise.
  always @(posedge clk) rom_rdata <= rom_req ? rom_fn(rom_addr) : 32'h0BAD_F00D;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_port(input int p);
    hsel[p] = 1'b0; hwrite[p] = 1'b0; hready[p] = 1'b1;
    htrans[p] = 2'b00; haddr[p] = '0; hsize[p] = 3'b010;
  endtask

  task automatic drive_port(input int p, input logic s, input logic r, input logic [1:0] t,
                            input logic w, input logic [31:0] a);
    hsel[p] = s; hready[p] = r; htrans[p] = t; hwrite[p] = w; haddr[p] = a; hsize[p] = 3'b010;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_port(0); idle_port(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          p;
    logic        s, r;
    logic [1:0]  t;
    logic        w;
    logic [31:0] a;
    logic        req;
    logic [15:0] raddr;
    logic        nrdy, nresp;
    logic [31:0] ndata;
  } vec_t;
  vec_t vt [8];

  // ---------------- transfer-level reference model ----------------
  logic [1:0]    m_ready, m_resp, m_pend, m_dv;
  logic [DW-1:0] m_data [2];
  logic [RW-1:0] m_paddr [2];
  int            m_err [2];
  int            m_last;
  int            dut_done [2];

  task automatic model_reset();
    m_ready = 2'b11; m_resp = 2'b00; m_pend = 2'b00; m_dv = 2'b00;
    m_last = 1;
    for (int p = 0; p < 2; p++) begin
      m_data[p] = '0; m_paddr[p] = '0; m_err[p] = 0; dut_done[p] = 0;
    end
  endtask

  task automatic model_cycle(input bit force_rd);
    logic [1:0]    newrd, wr, served;
    logic [RW-1:0] sa [2];
    logic          exp_req;
    logic [RW-1:0] exp_addr;
    for (int p = 0; p < 2; p++) begin
      if (m_ready[p]) begin
        if (force_rd) begin
          hsel[p] = 1'b1; htrans[p] = 2'($urandom_range(2, 3)); hwrite[p] = 1'b0;
        end else begin
          hsel[p]   = ($urandom_range(0, 3) != 0);
          htrans[p] = 2'($urandom_range(0, 3));
          hwrite[p] = ($urandom_range(0, 5) == 0);
        end
        haddr[p] = $urandom;
        hsize[p] = 3'($urandom_range(0, 2));
      end
      hready[p] = m_ready[p];
      newrd[p]  = hsel[p] & hready[p] & htrans[p][1] & ~hwrite[p];
      wr[p]     = hsel[p] & hready[p] & htrans[p][1] & hwrite[p];
      sa[p]     = m_pend[p] ? m_paddr[p] : haddr[p][RW-1:0];
    end
    served = 2'b00;
    if (m_pend[0])           served[0] = 1'b1;
    else if (m_pend[1])      served[1] = 1'b1;
    else if (newrd == 2'b11) served[1 - m_last] = 1'b1;
    else                     served = newrd;
    exp_req = |served;
    exp_addr = '0;
    for (int p = 0; p < 2; p++)
      if (served[p]) begin exp_addr = sa[p]; m_last = p; end

    @(negedge clk);
    chk("rom_req", 32'(rom_req), 32'(exp_req));
    if (exp_req) chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("p%0d hreadyout", p), 32'(hreadyout[p]), 32'(m_ready[p]));
      chk($sformatf("p%0d hresp", p), 32'(hresp[p]), 32'(m_resp[p]));
      chk($sformatf("p%0d hrdata", p), hrdata[p], m_data[p]);
      if (hreadyout[p] && m_dv[p] && hrdata[p] === m_data[p]) dut_done[p]++;
    end

    for (int p = 0; p < 2; p++) begin
      m_dv[p] = 1'b0; m_data[p] = '0;
      if (m_err[p] == 1) begin
        m_ready[p] = 1'b1; m_resp[p] = 1'b1; m_err[p] = 2;
      end else begin
        m_err[p] = 0;
        if (served[p]) begin
          m_ready[p] = 1'b1; m_resp[p] = 1'b0; m_data[p] = rom_fn(sa[p]); m_dv[p] = 1'b1; m_pend[p] = 1'b0;
        end else if (newrd[p]) begin
          m_ready[p] = 1'b0; m_resp[p] = 1'b0; m_pend[p] = 1'b1; m_paddr[p] = haddr[p][RW-1:0];
        end else if (wr[p] && WERR) begin
          m_ready[p] = 1'b0; m_resp[p] = 1'b1; m_err[p] = 1;
        end else begin
          m_ready[p] = 1'b1; m_resp[p] = 1'b0;
        end
      end
    end
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vt[0] = '{0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h1234_0020, 1'b1, 16'h0020, 1'b1, 1'b0, rom_fn(16'h0020)};
    vt[1] = '{1, 1'b1, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFC, 1'b1, 16'hFFFC, 1'b1, 1'b0, rom_fn(16'hFFFC)};
    vt[2] = '{0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0};
    vt[3] = '{1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0};
    vt[4] = '{0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0048, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0};
    vt[5] = '{1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_004C, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0};
    vt[6] = '{0, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0050, 1'b0, 16'h0000, !WERR, WERR, 32'h0};
    vt[7] = '{1, 1'b1, 1'b1, 2'b10, 1'b0, 32'hABCD_0000, 1'b1, 16'h0000, 1'b1, 1'b0, rom_fn(16'h0000)};

    // Reset values, with a read presented during reset to show no strobe leaks out.
    rst = 1'b1;
    idle_port(0); idle_port(1);
    drive_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0004);
    #2;
    chk("rst rom_req", 32'(rom_req), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rst p%0d hreadyout", p), 32'(hreadyout[p]), 32'd1);
      chk($sformatf("rst p%0d hresp", p), 32'(hresp[p]), 32'd0);
      chk($sformatf("rst p%0d hrdata", p), hrdata[p], 32'd0);
      chk($sformatf("rst p%0d state idle", p), 32'(dbg_state[p]), 32'd0);
    end
    do_reset();

    // Simultaneous reads right after reset: port 0 wins the first tie.
    drive_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0004);
    drive_port(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0008);
    @(negedge clk);
    chk("tie N rom_req", 32'(rom_req), 32'd1);
    chk("tie N rom_addr", 32'(rom_addr), 32'h0004);
    step();
    idle_port(0);
    hready[1] = 1'b0;
    @(negedge clk);
    chk("tie N+1 p0 hrdata", hrdata[0], rom_fn(16'h0004));
    chk("tie N+1 p0 hreadyout", 32'(hreadyout[0]), 32'd1);
    chk("tie N+1 p1 hreadyout", 32'(hreadyout[1]), 32'd0);
    chk("tie N+1 p1 hrdata", hrdata[1], 32'd0);
    chk("tie N+1 rom_req", 32'(rom_req), 32'd1);
    chk("tie N+1 rom_addr", 32'(rom_addr), 32'h0008);
    step();
    idle_port(1);
    @(negedge clk);
    chk("tie N+2 p1 hrdata", hrdata[1], rom_fn(16'h0008));
    chk("tie N+2 p1 hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("tie N+2 rom_req", 32'(rom_req), 32'd0);
    step();

    // Single uncontended read.
    drive_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010);
    @(negedge clk);
    chk("single rom_req", 32'(rom_req), 32'd1);
    chk("single rom_addr", 32'(rom_addr), 32'h0010);
    step();
    idle_port(0);
    @(negedge clk);
    chk("single hrdata0", hrdata[0], 32'hDEADBEEF);
    chk("single hreadyout0", 32'(hreadyout[0]), 32'd1);
    step();

    // Single-port vector table.
    for (int i = 0; i < 8; i++) begin
      idle_port(1 - vt[i].p);
      drive_port(vt[i].p, vt[i].s, vt[i].r, vt[i].t, vt[i].w, vt[i].a);
      @(negedge clk);
      chk($sformatf("vec%0d rom_req", i), 32'(rom_req), 32'(vt[i].req));
      if (vt[i].req) chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vt[i].raddr));
      step();
      idle_port(0); idle_port(1);
      @(negedge clk);
      chk($sformatf("vec%0d hreadyout", i), 32'(hreadyout[vt[i].p]), 32'(vt[i].nrdy));
      chk($sformatf("vec%0d hresp", i), 32'(hresp[vt[i].p]), 32'(vt[i].nresp));
      chk($sformatf("vec%0d hrdata", i), hrdata[vt[i].p], vt[i].ndata);
      step();
      step();
    end

    // Write to port 1.
    drive_port(1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0100);
    @(negedge clk);
    chk("wr N rom_req", 32'(rom_req), 32'd0);
    step();
    if (WERR) hready[1] = 1'b0;
    else      idle_port(1);
    @(negedge clk);
    chk("wr N+1 hresp1", 32'(hresp[1]), 32'(WERR));
    chk("wr N+1 hreadyout1", 32'(hreadyout[1]), 32'(!WERR));
    chk("wr N+1 rom_req", 32'(rom_req), 32'd0);
    step();
    idle_port(1);
    @(negedge clk);
    chk("wr N+2 hresp1", 32'(hresp[1]), 32'(WERR));
    chk("wr N+2 hreadyout1", 32'(hreadyout[1]), 32'd1);
    chk("wr N+2 rom_req", 32'(rom_req), 32'd0);
    step();
    @(negedge clk);
    chk("wr N+3 hresp1", 32'(hresp[1]), 32'd0);
    step();

    // Reset while port 1 sits in WAIT, with a fresh port 0 read on the bus.
    do_reset();
    drive_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040);
    drive_port(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0080);
    step();
    drive_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0044);
    hready[1] = 1'b0;
    @(negedge clk);
    chk("rstmid pre p1 hreadyout", 32'(hreadyout[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid p1 hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("rstmid rom_req", 32'(rom_req), 32'd0);
    chk("rstmid rom_addr", 32'(rom_addr), 32'd0);
    chk("rstmid p0 hrdata", hrdata[0], 32'd0);
    idle_port(0); idle_port(1);
    step();
    step();
    rst = 1'b0;
    drive_port(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_000C);
    @(negedge clk);
    chk("post-rst rom_req", 32'(rom_req), 32'd1);
    chk("post-rst rom_addr", 32'(rom_addr), 32'h000C);
    step();
    idle_port(0);
    @(negedge clk);
    chk("post-rst hreadyout0", 32'(hreadyout[0]), 32'd1);
    chk("post-rst hrdata0", hrdata[0], rom_fn(16'h000C));
    step();

    // Continuous reads on both ports: grants must alternate with at most one wait each.
    do_reset();
    model_reset();
    for (int c = 0; c < 20; c++) model_cycle(1'b1);
    chk("seq p0 transfers>=8", 32'(dut_done[0] >= 8), 32'd1);
    chk("seq p1 transfers>=8", 32'(dut_done[1] >= 8), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) model_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_rom_arbiter.md
# ahb_rom_arbiter

Two-port AHB-Lite slave front end that shares one single-port `boot_rom` macro (req/addr/rdata, 1-cycle read latency) between the instruction-fetch and data AHB buses. It accepts read transfers on both ports and arbitrates them onto the ROM round-robin. A losing port gets exactly one wait state. Write transfers are rejected or discarded per build configuration. It sits between the two bus matrices and the ROM macro, replacing per-bus ROM wrappers.

## Interface
Parameters:
- AHB_ADDR_WIDTH, 32, address width of both AHB ports
- AHB_DATA_WIDTH, 32, data width of ports and ROM
- ROM_ADDR_WIDTH, 16, byte-address bits forwarded to ROM (`haddr[ROM_ADDR_WIDTH-1:0]`)

Ports (`p` = 0 for the instruction port, 1 for the data port; each per-port signal exists twice, e.g. `hsel0_i`, `hsel1_i`):
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- hselp_i  in  1  slave select
- haddrp_i  in  AHB_ADDR_WIDTH  address
- hwritep_i  in  1  1 = write
- htransp_i  in  2  IDLE/BUSY/NONSEQ/SEQ
- hsizep_i  in  3  ignored; a full word is always returned
- hreadyp_i  in  1  bus-level HREADY
- hrdatap_o  out  AHB_DATA_WIDTH  read data
- hreadyoutp_o  out  1  slave ready
- hrespp_o  out  1  0 = OKAY, 1 = ERROR
- rom_req_o  out  1  ROM read strobe
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM byte address
- rom_rdata_i  in  AHB_DATA_WIDTH  ROM data, valid the cycle after `rom_req_o`

## Operation
- Address phase accepted on port p when `hselp_i & hreadyp_i & htransp_i[1]`. IDLE/BUSY transfers and unselected cycles produce a zero-wait OKAY and issue no ROM request.
- Each port has its own state machine:
  - IDLE → DATA: accepted read, granted this cycle.
  - IDLE → WAIT: accepted read, not granted. The address is latched.
  - WAIT → DATA: always granted next cycle.
  - DATA → IDLE, DATA, or WAIT: decided by the same-cycle new address phase.
  - IDLE → ERR1 → ERR2 → IDLE: write, only with ROM_ARB_WERR_EN.
- Arbitration is combinational in the cycle of request:
  - Candidates are new accepted reads and ports in WAIT.
  - A WAIT port always wins.
  - Otherwise a single candidate wins.
  - If both ports are new, the winner is the port not granted last (`last_gnt` register).
  - `last_gnt` updates on every grant.
- Grant drives `rom_req_o = 1` and `rom_addr_o`:
  - live `haddrp_i[ROM_ADDR_WIDTH-1:0]` for a new request;
  - the latched address for a WAIT port.
- DATA state: `hrdatap_o = rom_rdata_i`, `hreadyoutp_o = 1`, `hrespp_o = 0`. In every other state `hrdatap_o = 0`.
- WAIT state: `hreadyoutp_o = 0`, `hrespp_o = 0`.
- A port never holds more than one outstanding request. A new address phase cannot be accepted while that port's `hreadyp_i` is low.

## Timing
- Reset values (async, immediate): all `hreadyoutp_o = 1`, `hrespp_o = 0`, `hrdatap_o = 0`, `rom_req_o = 0`, `rom_addr_o = 0`. All port FSMs go to IDLE, pending addresses are cleared, `last_gnt = 1` (port 0 wins the first tie).
- Uncontended read: address phase cycle N, `rom_req_o` in N, data with `hreadyout = 1` in N+1. Zero wait states.
- Contended read: the loser sees `hreadyout = 0` in N+1, its ROM request is issued in N+1, data arrives in N+2. Exactly one wait state.
- Back-to-back contention: the port in WAIT beats a new request from the other port. That port then waits one cycle. No starvation; maximum wait is 1 cycle.
- `rom_req_o` is asserted at most once per cycle. It is never asserted for writes, IDLE, or BUSY.
- Reset mid-operation: outstanding transfers are abandoned and no data is returned. Outputs take their reset values in the same cycle.

## Configuration
- `ROM_ARB_WERR_EN` defined:
  - A write address phase yields an AHB two-cycle ERROR response.
  - ERR1: `hreadyout = 0`, `hresp = 1`.
  - ERR2: `hreadyout = 1`, `hresp = 1`.
  - No ROM request is issued.
- `ROM_ARB_WERR_EN` undefined:
  - Writes complete zero-wait OKAY and the data is discarded.
  - No ROM request is issued.
  - The ERR states are not compiled.

## Test plan
- Single read, port 0 @ 0x0000_0010, ROM returns 0xDEADBEEF: `rom_req_o`/`rom_addr_o = 0x0010` in cycle N; `hrdata0_o = 0xDEADBEEF`, `hreadyout0_o = 1` in N+1.
- Simultaneous reads after reset, port 0 @ 0x0004, port 1 @ 0x0008:
  - N: `rom_addr_o = 0x0004`.
  - N+1: port 0 data, `hreadyout1_o = 0`, `rom_addr_o = 0x0008`.
  - N+2: port 1 data.
- Both ports issue continuous SEQ reads for 8 transfers: grants alternate, each port sees at most 1 wait state per transfer, and no request is lost.
- Write to port 1 @ 0x0100: with `ROM_ARB_WERR_EN`, `hresp1_o` reads 1,1 and `hreadyout1_o` reads 0,1. Without it, zero-wait OKAY. `rom_req_o` stays 0 in both builds.
- Assert `rst` while port 1 is in WAIT: `hreadyout1_o = 1`, `rom_req_o = 0` immediately. After release, a port 0 read completes zero-wait.
